seqgen_tx: RTL and testbench
============================

Name: seqgen_tx

Overview:
- Serial pattern transmitter: loads a parallel bit pattern and shifts it out MSB-first, one bit per clock.
- Repeats the pattern a programmed number of times, with an optional idle gap between repeats.
- Is the stimulus/transmit end for the team's serial sequence detectors; dout drives a detector's in directly.
- Exports a 3-bit encoded state (statout) for LED/debug display, matching the detector-side status convention.

Parameters:
PAT_W, 6, pattern length in bits (≥2)
CNT_W, 4, width of repeat count
GAP_W, 3, width of inter-pattern gap length

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request transmission; sampled only in IDLE
pattern  input  PAT_W  bits to send, bit PAT_W-1 first
repeat_n  input  CNT_W  number of pattern repetitions (0 = none)
gap  input  GAP_W  idle cycles inserted between repetitions
abort  input  1  synchronous cancel
dout  output  1  serial data bit
dvalid  output  1  high while dout carries a pattern bit
busy  output  1  high from accepted start until done/abort completes
done  output  1  one-cycle pulse at normal completion
statout  output  3  encoded FSM state

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; dout=0, dvalid=0, busy=0, done=0, statout=000; all internal counters and shadow registers cleared. Reset mid-transmission aborts immediately with no done pulse.
- All outputs are registered. statout is a combinational decode of the state register.
- FSM states and statout codes: IDLE=000, SHIFT=001, GAP=010, DONE=011. Unused codes decode to 000.
- IDLE:
  - dout=0, dvalid=0, busy=0.
  - start=1 at edge T: latch pattern/repeat_n/gap into shadow registers; busy=1 from T+1.
  - If repeat_n≠0: go to SHIFT; first bit (pattern[PAT_W-1]) appears on dout with dvalid=1 in cycle T+1.
  - If repeat_n=0: go to DONE; no bits sent.
- SHIFT:
  - One bit per cycle, MSB first; bit counter counts 0..PAT_W-1; dvalid=1.
  - After the last bit of a repetition, decrement the remaining-repeat count.
  - Remaining=0: go to DONE.
  - Remaining>0 and gap=0: next repetition starts back-to-back, with no idle cycle.
  - Remaining>0 and gap>0: go to GAP.
- GAP:
  - Lasts exactly gap cycles; dout=0, dvalid=0, busy=1.
  - Then SHIFT restarts from the MSB of the shadow pattern.
- DONE:
  - Lasts one cycle: done=1, busy=1, dout=0, dvalid=0.
  - Then IDLE; busy=0 from the following cycle.
- Shadow registers: input changes during busy have no effect on the current transmission.
- start while busy (SHIFT/GAP/DONE): ignored, not queued.
- start held continuously: a new transmission is accepted in the first IDLE cycle after DONE.
- abort=1 in any non-IDLE state at edge T: state=IDLE at T+1; dout=0, dvalid=0, busy=0, done stays 0.
- abort in IDLE: no effect. abort has priority over start in the same cycle.
- Total busy cycles for N≥1: N·PAT_W + (N−1)·gap + 1 (DONE). For N=0: 1 cycle.

Test Plan:
1. Single send: pattern=101011, repeat_n=1, gap=0, start pulse at cycle 0 -> dout=1,0,1,0,1,1 on cycles 1–6 with dvalid=1; done=1 at cycle 7; busy=1 on cycles 1–7; statout=001 on 1–6, 011 on 7, 000 on 8.
2. Repeat with gap: pattern=101011, repeat_n=2, gap=2 -> bits on cycles 1–6; cycles 7–8 dout=0, dvalid=0, statout=010; bits again on 9–14; done at 15.
3. Back-to-back into detector: pattern=101011, repeat_n=3, gap=0, dout wired to detector in -> 18 contiguous valid bits; detector out pulses once per complete 101011 received; done at cycle 19.
4. Zero repeat: repeat_n=0, start -> DONE at cycle 1 (done=1, statout=011); dvalid never asserted; IDLE at cycle 2.
5. Abort and ignored start: start (pattern=110000, repeat_n=1); pulse start again at cycle 2 -> ignored; abort at cycle 3 -> cycle 4 IDLE, busy=0, done never pulses; a fresh start at cycle 5 sends its first bit at cycle 6.
6. Async reset mid-operation: repeat_n=2, drop rst at cycle 4 (between edges) -> outputs 0 and statout=000 immediately; after rst release, no residual output until a new start.

Source files
------------

// File: rtl/seqgen_tx.sv
// seqgen_tx: serial pattern transmitter, MSB-first, with repeats and
// optional idle gaps between repeats; drives a sequence detector input.
// Ports: clk, rst (async, active-low), start, pattern[PAT_W],
//   repeat_n[CNT_W], gap[GAP_W], abort -> dout, dvalid, busy, done,
//   statout[3] (IDLE=000 SHIFT=001 GAP=010 DONE=011).
module seqgen_tx #(
  parameter int PAT_W = 6,
  parameter int CNT_W = 4,
  parameter int GAP_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             dout,
  output logic             dvalid,
  output logic             busy,
  output logic             done,
  output logic [2:0]       statout
);

  localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BW-1:0] LAST = BW'(PAT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [BW-1:0]    bitcnt;
  logic [BW-1:0]    bit_n;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] rem_n;
  logic [GAP_W-1:0] gcnt;
  logic [GAP_W-1:0] gcnt_n;
  logic [PAT_W-1:0] pat_sh;
  logic [PAT_W-1:0] pat_n;
  logic [GAP_W-1:0] gap_sh;
  logic [GAP_W-1:0] gsh_n;

  logic             dout_n;
  logic             dvalid_n;
  logic             busy_n;
  logic             done_n;
  logic [BW-1:0]    idx_n;

  // State, counters, shadow copies and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      bitcnt <= '0;
      rem    <= '0;
      gcnt   <= '0;
      pat_sh <= '0;
      gap_sh <= '0;
      dout   <= 1'b0;
      dvalid <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      bitcnt <= bit_n;
      rem    <= rem_n;
      gcnt   <= gcnt_n;
      pat_sh <= pat_n;
      gap_sh <= gsh_n;
      dout   <= dout_n;
      dvalid <= dvalid_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  // Next state and counter updates.
  // bitcnt names the bit currently on dout; rem counts repeats
  // still in flight, including the one being shifted.
  always_comb begin
    state_n = state;
    bit_n   = bitcnt;
    rem_n   = rem;
    gcnt_n  = gcnt;
    pat_n   = pat_sh;
    gsh_n   = gap_sh;
    unique case (state)
      S_IDLE: begin
        if (start && !abort) begin
          pat_n = pattern;
          gsh_n = gap;
          rem_n = repeat_n;
          bit_n = '0;
          if (repeat_n != '0) state_n = S_SHIFT;
          else                state_n = S_DONE;
        end
      end
      S_SHIFT: begin
        if (bitcnt == LAST) begin
          bit_n = '0;
          rem_n = rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            state_n = S_DONE;
          end else if (gap_sh == '0) begin
            state_n = S_SHIFT;
          end else begin
            state_n = S_GAP;
            gcnt_n  = gap_sh - GAP_W'(1);
          end
        end else begin
          bit_n = bitcnt + BW'(1);
        end
      end
      S_GAP: begin
        if (gcnt == '0) begin
          state_n = S_SHIFT;
          bit_n   = '0;
        end else begin
          gcnt_n = gcnt - GAP_W'(1);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    if (abort && state != S_IDLE) begin
      state_n = S_IDLE;
      bit_n   = '0;
      rem_n   = '0;
      gcnt_n  = '0;
    end
  end

  // Output values for the next cycle, decoded from the next state
  // so that every output leaves a flop.
  always_comb begin
    idx_n    = LAST - bit_n;
    dout_n   = 1'b0;
    dvalid_n = 1'b0;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    unique case (state_n)
      S_SHIFT: begin
        dout_n   = pat_n[idx_n];
        dvalid_n = 1'b1;
        busy_n   = 1'b1;
      end
      S_GAP: begin
        busy_n = 1'b1;
      end
      S_DONE: begin
        busy_n = 1'b1;
        done_n = 1'b1;
      end
      default: begin
        busy_n = 1'b0;
      end
    endcase
  end

  always_comb begin
    unique case (state)
      S_SHIFT: statout = 3'b001;
      S_GAP:   statout = 3'b010;
      S_DONE:  statout = 3'b011;
      default: statout = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_seqgen_tx.sv
// tb_seqgen_tx: directed + random checks of seqgen_tx against a
// queue-based model of the expected per-cycle output stream.
module tb_seqgen_tx;

  localparam int PAT_W = 6;
  localparam int CNT_W = 4;
  localparam int GAP_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [CNT_W-1:0] repeat_n = '0;
  logic [GAP_W-1:0] gap = '0;
  logic             abort = 1'b0;
  logic             dout;
  logic             dvalid;
  logic             busy;
  logic             done;
  logic [2:0]       statout;

  seqgen_tx #(
    .PAT_W(PAT_W),
    .CNT_W(CNT_W),
    .GAP_W(GAP_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .pattern(pattern),
    .repeat_n(repeat_n),
    .gap(gap),
    .abort(abort),
    .dout(dout),
    .dvalid(dvalid),
    .busy(busy),
    .done(done),
    .statout(statout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected output word: {dout, dvalid, busy, done, statout}
  typedef logic [6:0] ent_t;
  localparam ent_t IDLE_E = 7'b0000000;

  ent_t q[$];
  ent_t cur = IDLE_E;

  function automatic ent_t mk(bit d, bit v, bit b, bit dn,
                              logic [2:0] s);
    return {d, v, b, dn, s};
  endfunction

  // Apply the edge's inputs to the model: a transmission is an
  // explicit list of the cycles it will occupy.
  task automatic model_edge();
    if (cur[4] && abort) begin
      q.delete();
      cur = IDLE_E;
    end else if (!cur[4] && start && !abort) begin
      for (int r = 0; r < int'(repeat_n); r++) begin
        for (int i = PAT_W - 1; i >= 0; i--)
          q.push_back(mk(pattern[i], 1, 1, 0, 3'd1));
        if (r < int'(repeat_n) - 1)
          for (int g = 0; g < int'(gap); g++)
            q.push_back(mk(0, 0, 1, 0, 3'd2));
      end
      q.push_back(mk(0, 0, 1, 1, 3'd3));
      cur = q.pop_front();
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
      cur = IDLE_E;
    end
  endtask

  function automatic ent_t dut_vec();
    return {dout, dvalid, busy, done, statout};
  endfunction

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk(tag, 32'(dut_vec()), 32'(cur));
  endtask

  task automatic go(input logic [PAT_W-1:0] p,
                    input logic [CNT_W-1:0] n,
                    input logic [GAP_W-1:0] g);
    pattern  = p;
    repeat_n = n;
    gap      = g;
    start    = 1'b1;
  endtask

  logic [PAT_W-1:0] win;
  int               hits;
  int               nbits;

  initial begin
    // Reset state
    #2;
    chk("rst_vec", 32'(dut_vec()), 32'(IDLE_E));
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold", 32'(dut_vec()), 32'(IDLE_E));
    rst = 1'b1;
    cyc("idle0");

    // 1: single send
    go(6'b101011, 4'd1, 3'd0);
    for (int k = 1; k <= 8; k++) begin
      cyc("t1");
      start = 1'b0;
      if (k == 1) chk("t1_first", 32'(dout), 32'd1);
      if (k == 7) chk("t1_done", 32'(done), 32'd1);
      if (k == 8) chk("t1_idle", 32'(statout), 32'd0);
    end

    // 2: repeat with gap
    go(6'b101011, 4'd2, 3'd2);
    for (int k = 1; k <= 16; k++) begin
      cyc("t2");
      start = 1'b0;
      pattern = 6'(k * 7);
      gap = 3'(k);
      if (k == 7) chk("t2_gap", 32'(statout), 32'd2);
      if (k == 9) chk("t2_rst", 32'(dout), 32'd1);
      if (k == 15) chk("t2_done", 32'(done), 32'd1);
    end

    // 3: back-to-back, count detector matches in the bit stream
    go(6'b101011, 4'd3, 3'd0);
    win = '0;
    hits = 0;
    nbits = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc("t3");
      start = 1'b0;
      if (dvalid) begin
        nbits++;
        win = {win[PAT_W-2:0], dout};
        if (nbits >= PAT_W && win == 6'b101011) hits++;
      end
      if (k == 19) chk("t3_done", 32'(done), 32'd1);
    end
    chk("t3_bits", 32'(nbits), 32'd18);
    chk("t3_hits", 32'(hits), 32'd3);

    // 4: zero repeat
    go(6'b111111, 4'd0, 3'd1);
    cyc("t4");
    start = 1'b0;
    chk("t4_st", 32'(statout), 32'd3);
    chk("t4_dv", 32'(dvalid), 32'd0);
    cyc("t4");
    chk("t4_idle", 32'(busy), 32'd0);

    // 5: ignored start, abort, fresh start
    go(6'b110000, 4'd1, 3'd0);
    cyc("t5");
    start = 1'b0;
    cyc("t5");
    go(6'b000001, 4'd5, 3'd0);
    cyc("t5");
    start = 1'b0;
    abort = 1'b1;
    cyc("t5");
    abort = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    go(6'b100000, 4'd1, 3'd0);
    cyc("t5");
    start = 1'b0;
    chk("t5_bit", 32'(dout), 32'd1);
    for (int k = 0; k < 7; k++) cyc("t5");

    // 6: async reset mid-operation
    go(6'b101101, 4'd2, 3'd1);
    cyc("t6");
    start = 1'b0;
    for (int k = 0; k < 3; k++) cyc("t6");
    #2 rst = 1'b0;
    #1;
    chk("t6_async", 32'(dut_vec()), 32'(IDLE_E));
    q.delete();
    cur = IDLE_E;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) cyc("t6_after");

    // Start held: next accepted the cycle after DONE's IDLE
    go(6'b010101, 4'd1, 3'd0);
    for (int k = 0; k < 20; k++) cyc("held");
    start = 1'b0;
    for (int k = 0; k < 10; k++) cyc("held");

    // Random traffic, inputs churn every cycle
    for (int k = 0; k < 3000; k++) begin
      start    = ($urandom % 4) == 0;
      abort    = ($urandom % 40) == 0;
      pattern  = PAT_W'($urandom);
      repeat_n = CNT_W'($urandom % 4);
      gap      = GAP_W'($urandom % 4);
      cyc("rand");
    end
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 40; k++) cyc("drain");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
